addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Sequencer and round-robin arbiter that shares one 4-bit adder/subtractor datapath between two requesters. Each requester submits operands and an add/subtract opcode over a valid/ready handshake. The block grants one request at a time, computes the result in a registered execute cycle, and returns result and flags over a per-requester response handshake. It sits between the client logic and the combinational add/sub datapath, which forms subtraction by adding the two's complement of B.

## Interface
- WIDTH, 4, operand and result width in bits; flag rules below hold for any WIDTH ≥ 2.
- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- Req_ready  output  2  per-requester accept; at most one bit high.
- Req_a  input  2*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- Req_b  input  2*WIDTH  operand B, packed the same way as Req_a.
- Req_sub  input  2  1 = A−B, 0 = A+B, per requester.
- Rsp_valid  output  2  result valid for requester i; at most one bit high.
- Rsp_ready  input  2  requester i accepts the response.
- Rsp_result  output  WIDTH  result, shared by both requesters and qualified by Rsp_valid.
- Rsp_carry  output  1  carry out; for subtraction, 1 = no borrow.
- Rsp_ovf  output  1  signed (two's complement) overflow.
- Rsp_zero  output  1  Rsp_result == 0.
- Busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any Req_valid bit is high, the arbiter picks grant g by round-robin.
  - Req_ready[g] is asserted combinationally in the same cycle.
  - A, B, Sub and g are captured on that edge, and the FSM moves to EXEC.
  - With no Req_valid high, the FSM stays in IDLE.
- Round-robin rule:
  - Pointer last_g resets to 1, so requester 0 wins the first simultaneous contest.
  - When both requesters are valid, the grant goes to the one that is not last_g.
  - When only one is valid, that one is granted.
  - last_g updates to g when the request is accepted.
- EXEC:
  - Bx = Sub ? ~B : B.
  - {carry, raw} = A + Bx + Sub, computed at WIDTH+1 bits.
  - ovf = (A[MSB] == Bx[MSB]) && (raw[MSB] != A[MSB]).
  - Result, carry, ovf and zero are registered, and the FSM moves to RESP unconditionally.
- RESP:
  - Rsp_valid[g] is high; result and flags are held stable.
  - When Rsp_ready[g] is high, the FSM returns to IDLE.
  - Rsp_ready of the non-granted requester is ignored.
- No new request is accepted outside IDLE; Req_ready = 0 in EXEC and RESP.
- Reset value of every output is 0: Req_ready, Rsp_valid, Rsp_result, Rsp_carry, Rsp_ovf, Rsp_zero and Busy.
- Reset mid-operation abandons the operation: FSM goes to IDLE, last_g to 1, Rsp_valid drops immediately, and no response is produced.
- Deasserting Req_valid while not granted is legal and causes no effect.

## Timing
- Request accepted on edge N (Req_valid & Req_ready) → Rsp_valid high from N+2.
- Response accepted on edge M → FSM is in IDLE at M+1, and Req_ready may assert in that same cycle.
- Minimum sustained throughput: one operation per 3 cycles.
- Req_ready depends combinationally on Req_valid and state.
- Rsp_* outputs come straight from registers.

## Configuration
- ADDSUB_SAT_EN defined:
  - On ovf, Rsp_result saturates to the signed limit: 0111 (A positive) or 1000 (A negative).
  - Rsp_ovf still reports the overflow.
  - Rsp_zero is computed on the saturated value.
- ADDSUB_SAT_EN undefined: Rsp_result is the raw wrap-around sum.
- Carry is unaffected by the macro.

## Structure
- Shared package addsub_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - WIDTH_DEFAULT = 4;
  - NREQ = 2.
- One sub-module, addsub_core: the combinational datapath (A, B, Sub → raw, carry, ovf), instantiated once inside addsub_arbiter.
- Arbiter, FSM and response registers live in the top module.

## Test plan
- Add, no overflow: Req 0 submits A=3, B=4, Sub=0 → Rsp_valid[0] at N+2 with result 0111, carry 0, ovf 0, zero 0.
- Signed overflow on add: A=7, B=1, Sub=0 → ovf 1, carry 0; result 1000 with ADDSUB_SAT_EN undefined, 0111 with it defined.
- Subtraction to zero and borrow:
  - A=5, B=5, Sub=1 → result 0000, zero 1, carry 1.
  - A=2, B=3, Sub=1 → result 1111, carry 0, ovf 0.
- Arbitration after reset:
  - Both requesters valid continuously → grants alternate 0, 1, 0, 1.
  - Each Rsp_valid appears only on its own bit.
  - Req_ready is never high outside IDLE.
- Response backpressure: hold Rsp_ready[g]=0 for 5 cycles → Rsp_valid and the result stay stable, no new grant occurs, and Busy stays 1.
- Reset in EXEC: Rst_n low → all outputs 0 immediately; after release, the next contested grant goes to requester 0.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package addsub_pkg;
  localparam int WIDTH_DEFAULT = 4;
  localparam int NREQ          = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor; subtraction adds the two's complement of b.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] raw,
  output logic             carry,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;

  assign bx             = sub ? ~b : b;
  assign {carry, raw}   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  // Overflow: operands of equal sign produce a result of the other sign.
  assign ovf            = (a[WIDTH-1] == bx[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin sequencer around one shared addsub_core.
// ADDSUB_SAT_EN: saturate the result to the signed limit on overflow.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_ovf,
  output logic                  rsp_zero,
  output logic                  busy
);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             g;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
  } rsp_t;

  state_t           state, state_nxt;
  req_t             req_q;
  rsp_t             rsp_q;
  logic             last_g, gnt, accept;
  logic [WIDTH-1:0] raw, res_sel;
  logic             carry, ovf;

  // Contested grant goes to whoever did not win last; otherwise the lone requester.
  assign gnt = (&req_valid) ? ~last_g : req_valid[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // req_ready is gated by rst_n so every output reads zero while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: if (rst_n && |req_valid) begin
        req_ready[gnt] = 1'b1;
        accept         = 1'b1;
        state_nxt      = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[req_q.g]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a     (req_q.a),
    .b     (req_q.b),
    .sub   (req_q.sub),
    .raw   (raw),
    .carry (carry),
    .ovf   (ovf)
  );

`ifdef ADDSUB_SAT_EN
  assign res_sel = !ovf          ? raw :
                   req_q.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_sel = raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_g    <= 1'b1;
      req_q     <= '0;
      rsp_q     <= '0;
      rsp_valid <= '0;
    end else begin
      if (accept) begin
        req_q  <= '{a:   req_a[gnt*WIDTH +: WIDTH],
                    b:   req_b[gnt*WIDTH +: WIDTH],
                    sub: req_sub[gnt],
                    g:   gnt};
        last_g <= gnt;
      end
      if (state == EXEC) begin
        rsp_q     <= '{result: res_sel, carry: carry, ovf: ovf, zero: (res_sel == '0)};
        rsp_valid <= NREQ'(1) << req_q.g;
      end else if (state == RESP && rsp_ready[req_q.g]) begin
        rsp_valid <= '0;
      end
    end
  end

  assign rsp_result = rsp_q.result;
  assign rsp_carry  = rsp_q.carry;
  assign rsp_ovf    = rsp_q.ovf;
  assign rsp_zero   = rsp_q.zero;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed, arbitration, backpressure, random, reset.
module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_sub = '0, rsp_ready = '0;
  logic [7:0] req_a = '0, req_b = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_ovf, rsp_zero, busy;

  int errors = 0;
  int checks = 0;
  int last   = 1;

  addsub_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {result, carry, ovf, zero}.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic sub);
    int ua, ub, sa, sb, u, s;
    logic [3:0] r;
    logic c, o;
    ua = int'(a); ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    if (sub) begin u = ua - ub; s = sa - sb; c = (ua >= ub); end
    else     begin u = ua + ub; s = sa + sb; c = (u > 15);   end
    r = u[3:0];
    o = (s > 7) || (s < -8);
`ifdef ADDSUB_SAT_EN
    if (o) r = (s > 7) ? 4'd7 : 4'd8;
`endif
    return {r, c, o, (r == 4'd0)};
  endfunction

  logic [3:0] da [4] = '{4'd3, 4'd7, 4'd5, 4'd2};
  logic [3:0] db [4] = '{4'd4, 4'd1, 4'd5, 4'd3};
  logic       ds [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef ADDSUB_SAT_EN
  logic [6:0] dexp [4] = '{7'b0111_000, 7'b0111_010, 7'b0000_101, 7'b1111_000};
`else
  logic [6:0] dexp [4] = '{7'b0111_000, 7'b1000_010, 7'b0000_101, 7'b1111_000};
`endif

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero, busy});
    end
    rst_n = 1'b1; last = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: busy=%b ready=%b want 0/00", busy, req_ready);
    end
  endtask

  task automatic test_directed;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_a[3:0] = da[i]; req_b[3:0] = db[i]; req_sub[0] = ds[i]; req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
        errors++; $display("FAIL dir_ready[%0d]: got %b want 01", i, req_ready);
      end
      @(negedge clk);
      req_valid = '0; last = 0;
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
        errors++; $display("FAIL dir_exec[%0d]: busy=%b rsp_valid=%b want 1/00", i, busy, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01) begin
        errors++; $display("FAIL dir_latency[%0d]: rsp_valid=%b want 01", i, rsp_valid);
      end
      checks++;
      if ({rsp_result, rsp_carry, rsp_ovf, rsp_zero} !== dexp[i]) begin
        errors++; $display("FAIL dir_result[%0d]: got %b want %b", i,
                           {rsp_result, rsp_carry, rsp_ovf, rsp_zero}, dexp[i]);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = '0;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++; $display("FAIL dir_release[%0d]: rsp_valid=%b busy=%b want 00/0", i, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_alternate;
    int g;
    logic [1:0] gb;
    logic [6:0] exp;
    test_reset();
    req_a = 8'h5A; req_b = 8'h3C; req_sub = 2'b10;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g  = 1 - last;
      gb = (g == 1) ? 2'b10 : 2'b01;
      exp = model(req_a[g*4 +: 4], req_b[g*4 +: 4], req_sub[g]);
      #1;
      checks++;
      if (req_ready !== gb) begin
        errors++; $display("FAIL alt_grant[%0d]: got %b want %b", k, req_ready, gb);
      end
      last = g;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL alt_exec_ready[%0d]: ready=%b busy=%b want 00/1", k, req_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== gb || {rsp_result, rsp_carry, rsp_ovf, rsp_zero} !== exp) begin
        errors++; $display("FAIL alt_rsp[%0d]: valid=%b res=%b want %b/%b", k, rsp_valid,
                           {rsp_result, rsp_carry, rsp_ovf, rsp_zero}, gb, exp);
      end
      @(negedge clk);
      if (k == 3) begin req_valid = '0; rsp_ready = '0; end
    end
  endtask

  task automatic test_backpressure;
    logic [6:0] exp;
    @(negedge clk);
    req_a = 8'h96; req_b = 8'h4E; req_sub = 2'b01; req_valid = 2'b10;
    exp = model(4'h9, 4'h4, 1'b0);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL bp_grant: got %b want 10", req_ready);
    end
    @(negedge clk);
    last = 1; req_valid = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 2'b10 || {rsp_result, rsp_carry, rsp_ovf, rsp_zero} !== exp ||
          busy !== 1'b1 || req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b res=%b busy=%b ready=%b want 10/%b/1/00",
                           c, rsp_valid, {rsp_result, rsp_carry, rsp_ovf, rsp_zero}, busy, req_ready, exp);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_release: valid=%b busy=%b ready=%b want 00/0/01", rsp_valid, busy, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_random;
    int g, d;
    logic [1:0] rv, gb;
    logic [6:0] exp;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rv = 2'($urandom_range(1, 3));
      req_a = 8'($urandom); req_b = 8'($urandom); req_sub = 2'($urandom); req_valid = rv;
      g  = (rv == 2'b11) ? 1 - last : (rv == 2'b10 ? 1 : 0);
      gb = (g == 1) ? 2'b10 : 2'b01;
      exp = model(req_a[g*4 +: 4], req_b[g*4 +: 4], req_sub[g]);
      #1;
      checks++;
      if (req_ready !== gb) begin
        errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", n, req_ready, gb);
      end
      @(negedge clk);
      last = g;
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL rnd_exec[%0d]: ready=%b busy=%b want 00/1", n, req_ready, busy);
      end
      req_a = 8'($urandom); req_b = 8'($urandom); req_valid = 2'($urandom);
      @(negedge clk);
      d = $urandom_range(0, 3);
      rsp_ready = ~gb;
      repeat (d) @(negedge clk);
      checks++;
      if (rsp_valid !== gb || {rsp_result, rsp_carry, rsp_ovf, rsp_zero} !== exp) begin
        errors++; $display("FAIL rnd_rsp[%0d]: valid=%b res=%b want %b/%b", n, rsp_valid,
                           {rsp_result, rsp_carry, rsp_ovf, rsp_zero}, gb, exp);
      end
      rsp_ready = gb; req_valid = '0;
      @(negedge clk);
      rsp_ready = '0;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++; $display("FAIL rnd_release[%0d]: valid=%b busy=%b want 00/0", n, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_reset_exec;
    @(negedge clk);
    req_a = 8'h17; req_b = 8'h22; req_sub = 2'b00; req_valid = 2'b01;
    @(negedge clk);
    last = 0;
    req_valid = 2'b11; rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero, busy} !== 11'd0) begin
      errors++;
      $display("FAIL rst_exec_outputs: got %b want 0",
               {req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_zero, busy});
    end
    @(negedge clk);
    rst_n = 1'b1; last = 1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_exec_regrant: got %b want 01", req_ready);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_exec_no_rsp: valid=%b busy=%b want 00/0", rsp_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_alternate();
    test_backpressure();
    test_random();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
